// File: rtl/bip_debug_sequencer.sv
// Host-side debug sequencer: loads program memory from a UART byte stream, runs or
// single-steps the accumulator CPU, and dumps a PC/ACC/cycle-count snapshot back.
module bip_debug_sequencer #(
    parameter int unsigned NBITS_D = 16,
    parameter int unsigned NBITS_A = 11,
    parameter int unsigned NBITS_C = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [7:0]         i_rx_data,
    input  logic               i_rx_valid,
    output logic               o_rx_ready,
    output logic [7:0]         o_tx_data,
    output logic               o_tx_valid,
    input  logic               i_tx_ready,
    output logic               o_prog_we,
    output logic [NBITS_A-1:0] o_prog_addr,
    output logic [NBITS_D-1:0] o_prog_wdata,
    output logic               o_cpu_reset,
    output logic               o_cpu_en,
    input  logic               i_cpu_halt,
    input  logic [NBITS_A-1:0] i_cpu_pc,
    input  logic [NBITS_D-1:0] i_cpu_acc,
    output logic               o_busy
);

    localparam int unsigned NBYTES_DUMP = 6;

    typedef enum logic [3:0] {
        S_IDLE, S_LD_NH, S_LD_NL, S_LD_WH, S_LD_WL, S_LD_WR,
        S_RUN_RST, S_RUN, S_STEP, S_DUMP
    } state_t;

    state_t             state;
    logic [7:0]         n_hi;
    logic [7:0]         w_hi;
    logic [15:0]        remaining;
    logic [NBITS_A-1:0] prog_addr;
    logic [NBITS_D-1:0] prog_wdata;
    logic [NBITS_C-1:0] cycle_cnt;
    logic [NBITS_A-1:0] snap_pc;
    logic [NBITS_D-1:0] snap_acc;
    logic [7:0]         tx_data;
    logic               tx_valid;
    logic [2:0]         byte_idx;

    logic               rx_fire_c;
    logic               cnt_max_c;
    logic [NBITS_A-1:0] pc_src_c;
    logic [NBITS_D-1:0] acc_src_c;
    logic [47:0]        dump_word_c;
    logic [7:0]         tx_byte_c;

    assign rx_fire_c = i_rx_valid & o_rx_ready;
    assign cnt_max_c = &cycle_cnt;

    // The first dump byte is built while the snapshot is being captured, so it uses the live PC/ACC.
    always_comb begin
        pc_src_c    = (byte_idx == 3'd0) ? i_cpu_pc  : snap_pc;
        acc_src_c   = (byte_idx == 3'd0) ? i_cpu_acc : snap_acc;
        dump_word_c = {16'(pc_src_c), 16'(acc_src_c), 16'(cycle_cnt)};
        case (byte_idx)
            3'd0:    tx_byte_c = dump_word_c[47:40];
            3'd1:    tx_byte_c = dump_word_c[39:32];
            3'd2:    tx_byte_c = dump_word_c[31:24];
            3'd3:    tx_byte_c = dump_word_c[23:16];
            3'd4:    tx_byte_c = dump_word_c[15:8];
            default: tx_byte_c = dump_word_c[7:0];
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= S_IDLE;
            n_hi       <= '0;
            w_hi       <= '0;
            remaining  <= '0;
            prog_addr  <= '0;
            prog_wdata <= '0;
            cycle_cnt  <= '0;
            snap_pc    <= '0;
            snap_acc   <= '0;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
            byte_idx   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (rx_fire_c) begin
                        case (i_rx_data)
                            8'h4C:   state <= S_LD_NH;
                            8'h52:   state <= S_RUN_RST;
                            8'h53:   state <= S_STEP;
                            default: state <= S_IDLE;
                        endcase
                    end
                end
                S_LD_NH: begin
                    if (rx_fire_c) begin
                        n_hi  <= i_rx_data;
                        state <= S_LD_NL;
                    end
                end
                S_LD_NL: begin
                    if (rx_fire_c) begin
                        prog_addr <= '0;
                        remaining <= {n_hi, i_rx_data};
                        state     <= ({n_hi, i_rx_data} == 16'd0) ? S_IDLE : S_LD_WH;
                    end
                end
                S_LD_WH: begin
                    if (rx_fire_c) begin
                        w_hi  <= i_rx_data;
                        state <= S_LD_WL;
                    end
                end
                S_LD_WL: begin
                    if (rx_fire_c) begin
                        prog_wdata <= NBITS_D'({w_hi, i_rx_data});
                        state      <= S_LD_WR;
                    end
                end
                S_LD_WR: begin
                    prog_addr <= prog_addr + NBITS_A'(1);
                    remaining <= remaining - 16'd1;
                    state     <= (remaining == 16'd1) ? S_IDLE : S_LD_WH;
                end
                S_RUN_RST: begin
                    cycle_cnt <= '0;
                    state     <= S_RUN;
                end
                S_RUN: begin
                    if (i_cpu_halt || cnt_max_c) begin
                        byte_idx <= '0;
                        tx_valid <= 1'b0;
                        state    <= S_DUMP;
                    end else begin
                        cycle_cnt <= cycle_cnt + NBITS_C'(1);
                    end
                end
                S_STEP: begin
                    if (!i_cpu_halt && !cnt_max_c) begin
                        cycle_cnt <= cycle_cnt + NBITS_C'(1);
                    end
                    byte_idx <= '0;
                    tx_valid <= 1'b0;
                    state    <= S_DUMP;
                end
                S_DUMP: begin
                    // Alternate load/handshake phases: one byte per two cycles at best.
                    if (!tx_valid) begin
                        if (byte_idx == 3'd0) begin
                            snap_pc  <= i_cpu_pc;
                            snap_acc <= i_cpu_acc;
                        end
                        tx_data  <= tx_byte_c;
                        tx_valid <= 1'b1;
                    end else if (i_tx_ready) begin
                        tx_valid <= 1'b0;
                        if (byte_idx == 3'(NBYTES_DUMP - 1)) begin
                            state <= S_IDLE;
                        end else begin
                            byte_idx <= byte_idx + 3'd1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // CPU enable follows halt/saturation in the same cycle so no instruction runs past HALT.
    always_comb begin
        o_cpu_en = 1'b0;
        case (state)
            S_RUN:   o_cpu_en = ~i_cpu_halt & ~cnt_max_c;
            S_STEP:  o_cpu_en = ~i_cpu_halt;
            default: o_cpu_en = 1'b0;
        endcase
    end

    assign o_rx_ready   = (state == S_IDLE) || (state == S_LD_NH) || (state == S_LD_NL) ||
                          (state == S_LD_WH) || (state == S_LD_WL);
    assign o_prog_we    = (state == S_LD_WR);
    assign o_cpu_reset  = (state == S_RUN_RST);
    assign o_busy       = (state != S_IDLE);
    assign o_prog_addr  = prog_addr;
    assign o_prog_wdata = prog_wdata;
    assign o_tx_data    = tx_data;
    assign o_tx_valid   = tx_valid;

endmodule

// File: tb/tb_bip_debug_sequencer.sv
// Directed bench: default-width sequencer plus a narrow one (2-bit address, 4-bit counter)
// sharing the UART-side stimulus through a select bit.
module tb_bip_debug_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       tx_ready = 1'b0;
    logic       sel = 1'b0;
    logic       halt_mode = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Main DUT and its CPU model: PC advances per enable, halts at PC 5 when halt_mode, ACC = PC + 2.
    logic        m_rx_ready, m_tx_valid, m_prog_we, m_cpu_reset, m_cpu_en, m_busy;
    logic [7:0]  m_tx_data;
    logic [10:0] m_prog_addr;
    logic [15:0] m_prog_wdata;
    logic [10:0] m_pc = 11'd0;
    logic        m_halt;
    logic [15:0] m_acc;
    assign m_halt = halt_mode && (m_pc == 11'd5);
    assign m_acc  = 16'(m_pc) + 16'd2;
    always @(posedge clk) begin
        if (m_cpu_reset) m_pc <= 11'd0;
        else if (m_cpu_en) m_pc <= m_pc + 11'd1;
    end

    bip_debug_sequencer dut (
        .i_clk(clk), .i_reset(rst),
        .i_rx_data(rx_data), .i_rx_valid(rx_valid & ~sel), .o_rx_ready(m_rx_ready),
        .o_tx_data(m_tx_data), .o_tx_valid(m_tx_valid), .i_tx_ready(tx_ready & ~sel),
        .o_prog_we(m_prog_we), .o_prog_addr(m_prog_addr), .o_prog_wdata(m_prog_wdata),
        .o_cpu_reset(m_cpu_reset), .o_cpu_en(m_cpu_en), .i_cpu_halt(m_halt),
        .i_cpu_pc(m_pc), .i_cpu_acc(m_acc), .o_busy(m_busy)
    );

    // Narrow DUT: never halts, so runs end on counter saturation.
    logic        s_rx_ready, s_tx_valid, s_prog_we, s_cpu_reset, s_cpu_en, s_busy;
    logic [7:0]  s_tx_data;
    logic [1:0]  s_prog_addr;
    logic [15:0] s_prog_wdata;
    logic [1:0]  s_pc = 2'd0;
    logic [15:0] s_acc;
    assign s_acc = 16'(s_pc) + 16'd2;
    always @(posedge clk) begin
        if (s_cpu_reset) s_pc <= 2'd0;
        else if (s_cpu_en) s_pc <= s_pc + 2'd1;
    end

    bip_debug_sequencer #(.NBITS_D(16), .NBITS_A(2), .NBITS_C(4)) dut_s (
        .i_clk(clk), .i_reset(rst),
        .i_rx_data(rx_data), .i_rx_valid(rx_valid & sel), .o_rx_ready(s_rx_ready),
        .o_tx_data(s_tx_data), .o_tx_valid(s_tx_valid), .i_tx_ready(tx_ready & sel),
        .o_prog_we(s_prog_we), .o_prog_addr(s_prog_addr), .o_prog_wdata(s_prog_wdata),
        .o_cpu_reset(s_cpu_reset), .o_cpu_en(s_cpu_en), .i_cpu_halt(1'b0),
        .i_cpu_pc(s_pc), .i_cpu_acc(s_acc), .o_busy(s_busy)
    );

    logic        rx_ready_x, tx_valid_x, we_x, cpu_reset_x, cpu_en_x, busy_x;
    logic [7:0]  tx_data_x;
    logic [10:0] addr_x;
    logic [15:0] wdata_x;
    assign rx_ready_x  = sel ? s_rx_ready  : m_rx_ready;
    assign tx_valid_x  = sel ? s_tx_valid  : m_tx_valid;
    assign tx_data_x   = sel ? s_tx_data   : m_tx_data;
    assign we_x        = sel ? s_prog_we   : m_prog_we;
    assign addr_x      = sel ? 11'(s_prog_addr) : m_prog_addr;
    assign wdata_x     = sel ? s_prog_wdata : m_prog_wdata;
    assign cpu_reset_x = sel ? s_cpu_reset : m_cpu_reset;
    assign cpu_en_x    = sel ? s_cpu_en    : m_cpu_en;
    assign busy_x      = sel ? s_busy      : m_busy;

    // Event logs sampled mid-cycle on the selected DUT.
    int          we_n = 0, en_n = 0, crst_n = 0;
    logic [10:0] we_addr [8];
    logic [15:0] we_data [8];
    always @(negedge clk) begin
        if (we_x) begin
            if (we_n < 8) begin
                we_addr[we_n] = addr_x;
                we_data[we_n] = wdata_x;
            end
            we_n++;
        end
        if (cpu_en_x) en_n++;
        if (cpu_reset_x) crst_n++;
    end

    logic [7:0] dump_bytes [6];
    bit         dump_timeout, dump_unstable;

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        @(negedge clk);
        rx_data = b;
        rx_valid = 1'b1;
        while (!rx_ready_x && t < 100) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (!rx_ready_x) begin
            errors++;
            $display("FAIL rx_accept byte=%02h: rx_ready stuck at 0, required 1", b);
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic get_dump(input int nbytes, input int stall);
        dump_timeout = 1'b0;
        dump_unstable = 1'b0;
        for (int i = 0; i < nbytes; i++) begin
            int t;
            logic [7:0] d;
            t = 0;
            while (!tx_valid_x && t < 300) begin
                @(negedge clk);
                t++;
            end
            if (!tx_valid_x) begin
                dump_timeout = 1'b1;
                return;
            end
            d = tx_data_x;
            for (int k = 0; k < stall; k++) begin
                @(negedge clk);
                if (!tx_valid_x || tx_data_x !== d) dump_unstable = 1'b1;
            end
            tx_ready = 1'b1;
            dump_bytes[i] = tx_data_x;
            @(negedge clk);
            tx_ready = 1'b0;
        end
    endtask

    task automatic clear_logs();
        we_n = 0;
        en_n = 0;
        crst_n = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (m_rx_ready !== 1'b1) begin errors++; $display("FAIL reset_rx_ready got=%b exp=1", m_rx_ready); end
        checks++; if (m_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", m_busy); end
        checks++; if (m_tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got=%b exp=0", m_tx_valid); end
        checks++; if (m_prog_we !== 1'b0) begin errors++; $display("FAIL reset_prog_we got=%b exp=0", m_prog_we); end
        checks++; if (m_cpu_en !== 1'b0 || m_cpu_reset !== 1'b0) begin errors++; $display("FAIL reset_cpu got en=%b rst=%b exp 0/0", m_cpu_en, m_cpu_reset); end
        checks++; if (m_prog_addr !== 11'd0 || m_prog_wdata !== 16'd0) begin errors++; $display("FAIL reset_prog got addr=%h data=%h exp 0/0", m_prog_addr, m_prog_wdata); end
        checks++; if (m_tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got=%h exp=00", m_tx_data); end
        checks++; if (s_busy !== 1'b0 || s_rx_ready !== 1'b1) begin errors++; $display("FAIL reset_narrow got busy=%b ready=%b exp 0/1", s_busy, s_rx_ready); end
    endtask

    task automatic test_load();
        logic [7:0] seq [7];
        seq = '{8'h4C, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
        sel = 1'b0;
        clear_logs();
        foreach (seq[i]) send_byte(seq[i]);
        repeat (2) @(negedge clk);
        checks++; if (we_n !== 2) begin errors++; $display("FAIL load_we_count got=%0d exp=2", we_n); end
        checks++; if (we_addr[0] !== 11'd0 || we_data[0] !== 16'h1234) begin errors++; $display("FAIL load_word0 got addr=%0d data=%h exp 0/1234", we_addr[0], we_data[0]); end
        checks++; if (we_addr[1] !== 11'd1 || we_data[1] !== 16'hABCD) begin errors++; $display("FAIL load_word1 got addr=%0d data=%h exp 1/abcd", we_addr[1], we_data[1]); end
        checks++; if (busy_x !== 1'b0) begin errors++; $display("FAIL load_idle got busy=%b exp=0", busy_x); end
    endtask

    task automatic test_load_zero();
        sel = 1'b0;
        clear_logs();
        send_byte(8'h4C); send_byte(8'h00); send_byte(8'h00);
        repeat (3) @(negedge clk);
        checks++; if (we_n !== 0) begin errors++; $display("FAIL load_n0_writes got=%0d exp=0", we_n); end
        checks++; if (busy_x !== 1'b0) begin errors++; $display("FAIL load_n0_idle got busy=%b exp=0", busy_x); end
    endtask

    task automatic test_unknown();
        sel = 1'b0;
        clear_logs();
        send_byte(8'h41);
        checks++; if (busy_x !== 1'b0 || rx_ready_x !== 1'b1) begin errors++; $display("FAIL unknown_idle got busy=%b ready=%b exp 0/1", busy_x, rx_ready_x); end
        repeat (3) @(negedge clk);
        checks++; if (we_n !== 0 || en_n !== 0 || crst_n !== 0) begin errors++; $display("FAIL unknown_side_effects got we=%0d en=%0d rst=%0d exp 0/0/0", we_n, en_n, crst_n); end
    endtask

    task automatic test_run_halt();
        logic [47:0] exp;
        exp = 48'h0005_0007_0005;
        sel = 1'b0;
        halt_mode = 1'b1;
        clear_logs();
        send_byte(8'h52);
        get_dump(6, 0);
        checks++; if (dump_timeout) begin errors++; $display("FAIL run_dump_timeout got=timeout exp=6 bytes"); end
        checks++; if (crst_n !== 1) begin errors++; $display("FAIL run_cpu_reset_pulses got=%0d exp=1", crst_n); end
        checks++; if (en_n !== 5) begin errors++; $display("FAIL run_en_cycles got=%0d exp=5", en_n); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (dump_bytes[i] !== exp[47-8*i -: 8]) begin errors++; $display("FAIL run_dump_byte%0d got=%02h exp=%02h", i, dump_bytes[i], exp[47-8*i -: 8]); end
        end
        checks++; if (busy_x !== 1'b0) begin errors++; $display("FAIL run_idle got busy=%b exp=0", busy_x); end
    endtask

    task automatic test_step();
        logic [47:0] exp;
        exp = 48'h0006_0008_0006;
        sel = 1'b0;
        halt_mode = 1'b0;
        clear_logs();
        send_byte(8'h53);
        get_dump(6, 0);
        checks++; if (dump_timeout) begin errors++; $display("FAIL step_dump_timeout got=timeout exp=6 bytes"); end
        checks++; if (en_n !== 1 || crst_n !== 0) begin errors++; $display("FAIL step_en got en=%0d rst=%0d exp 1/0", en_n, crst_n); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (dump_bytes[i] !== exp[47-8*i -: 8]) begin errors++; $display("FAIL step_dump_byte%0d got=%02h exp=%02h", i, dump_bytes[i], exp[47-8*i -: 8]); end
        end
    endtask

    task automatic test_backpressure();
        logic [47:0] exp;
        int extra;
        exp = 48'h0007_0009_0007;
        extra = 0;
        sel = 1'b0;
        clear_logs();
        send_byte(8'h53);
        get_dump(6, 10);
        checks++; if (dump_timeout) begin errors++; $display("FAIL bp_dump_timeout got=timeout exp=6 bytes"); end
        checks++; if (dump_unstable) begin errors++; $display("FAIL bp_tx_stable got=changed exp=stable while valid"); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (dump_bytes[i] !== exp[47-8*i -: 8]) begin errors++; $display("FAIL bp_dump_byte%0d got=%02h exp=%02h", i, dump_bytes[i], exp[47-8*i -: 8]); end
        end
        tx_ready = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (tx_valid_x) extra++;
        end
        tx_ready = 1'b0;
        checks++; if (extra !== 0) begin errors++; $display("FAIL bp_no_extra_bytes got=%0d exp=0", extra); end
    endtask

    task automatic test_load_wrap();
        sel = 1'b1;
        clear_logs();
        send_byte(8'h4C); send_byte(8'h00); send_byte(8'h05);
        for (int w = 1; w <= 5; w++) begin
            send_byte(8'h00);
            send_byte(8'(w));
        end
        repeat (2) @(negedge clk);
        checks++; if (we_n !== 5) begin errors++; $display("FAIL wrap_we_count got=%0d exp=5", we_n); end
        checks++; if (we_addr[3] !== 11'd3 || we_data[3] !== 16'h0004) begin errors++; $display("FAIL wrap_word3 got addr=%0d data=%h exp 3/0004", we_addr[3], we_data[3]); end
        checks++; if (we_addr[4] !== 11'd0 || we_data[4] !== 16'h0005) begin errors++; $display("FAIL wrap_word4 got addr=%0d data=%h exp 0/0005", we_addr[4], we_data[4]); end
        sel = 1'b0;
    endtask

    task automatic test_saturate();
        logic [47:0] exp;
        exp = 48'h0003_0005_000F;
        sel = 1'b1;
        clear_logs();
        send_byte(8'h52);
        get_dump(6, 0);
        checks++; if (dump_timeout) begin errors++; $display("FAIL sat_dump_timeout got=timeout exp=6 bytes"); end
        checks++; if (en_n !== 15) begin errors++; $display("FAIL sat_en_cycles got=%0d exp=15", en_n); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (dump_bytes[i] !== exp[47-8*i -: 8]) begin errors++; $display("FAIL sat_dump_byte%0d got=%02h exp=%02h", i, dump_bytes[i], exp[47-8*i -: 8]); end
        end
        sel = 1'b0;
    endtask

    task automatic test_reset_mid_dump();
        logic [23:0] exp;
        int extra;
        exp = 24'h00_08_00;
        extra = 0;
        sel = 1'b0;
        clear_logs();
        send_byte(8'h53);
        get_dump(3, 0);
        checks++; if (dump_timeout) begin errors++; $display("FAIL abort_dump_timeout got=timeout exp=3 bytes"); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (dump_bytes[i] !== exp[23-8*i -: 8]) begin errors++; $display("FAIL abort_dump_byte%0d got=%02h exp=%02h", i, dump_bytes[i], exp[23-8*i -: 8]); end
        end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (tx_valid_x !== 1'b0) begin errors++; $display("FAIL abort_tx_valid got=%b exp=0", tx_valid_x); end
        checks++; if (busy_x !== 1'b0) begin errors++; $display("FAIL abort_idle got busy=%b exp=0", busy_x); end
        rst = 1'b0;
        tx_ready = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (tx_valid_x) extra++;
        end
        tx_ready = 1'b0;
        checks++; if (extra !== 0) begin errors++; $display("FAIL abort_no_more_bytes got=%0d exp=0", extra); end
        checks++; if (crst_n !== 0) begin errors++; $display("FAIL abort_cpu_reset got=%0d exp=0", crst_n); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_load_zero();
        test_unknown();
        test_run_halt();
        test_step();
        test_backpressure();
        test_load_wrap();
        test_saturate();
        test_reset_mid_dump();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
